// File: rtl/rv32i_pkg.sv
// Shared RV32I opcode/funct3 constants and the decode payload type,
// used by the decode stage and the ALU.
package rv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SRL  = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } funct3_e;

    typedef struct packed {
        logic [2:0]  funct3;
        logic        mod;
        logic        immediate;
        logic [31:0] val1;
        logic [31:0] val2;
        logic [4:0]  rd;
        logic        illegal;
    } id_payload_t;

    function automatic logic signed [31:0] imm_i_sext(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

endpackage

// File: rtl/regfile.sv
// 32-entry register file: two asynchronous read ports, one synchronous write
// port, synchronous clear. x0 always reads as zero and ignores writes.
module regfile #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [4:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [4:0]        i_raddr1,
    input  logic [4:0]        i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2
);

    logic [DATA_W-1:0] r_mem [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == 5'd0) ? '0 : r_mem[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 5'd0) ? '0 : r_mem[i_raddr2];

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register read, OP/OP-IMM decode, single-entry payload register.
// Optional RV32I_WB_BYPASS_EN forwards a same-cycle write-back onto the source operands.
module id_stage
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instr,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [2:0]  ex_funct3,
    output logic        ex_mod,
    output logic        ex_immediate,
    output logic [31:0] ex_val1,
    output logic [31:0] ex_val2,
    output logic [4:0]  ex_rd,
    output logic        ex_illegal,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data
);

    localparam int DATA_W = 32;

    logic [6:0]        w_opcode;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic [2:0]        w_f3;
    logic [DATA_W-1:0] w_rf_rd1;
    logic [DATA_W-1:0] w_rf_rd2;
    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;
    logic              w_capture;
    id_payload_t       w_dec;

    logic              r_vld_p1;
    id_payload_t       r_pl_p1;

    assign w_opcode = if_instr[6:0];
    assign w_rs1    = if_instr[19:15];
    assign w_rs2    = if_instr[24:20];
    assign w_f3     = if_instr[14:12];

    regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_we     (wb_en),
        .i_waddr  (wb_rd),
        .i_wdata  (wb_data),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rf_rd1),
        .o_rdata2 (w_rf_rd2)
    );

`ifdef RV32I_WB_BYPASS_EN
    assign w_op1 = (wb_en && (wb_rd != 5'd0) && (wb_rd == w_rs1)) ? wb_data : w_rf_rd1;
    assign w_op2 = (wb_en && (wb_rd != 5'd0) && (wb_rd == w_rs2)) ? wb_data : w_rf_rd2;
`else
    assign w_op1 = w_rf_rd1;
    assign w_op2 = w_rf_rd2;
`endif

    // Stage p0: combinational decode of the fetched word
    always_comb begin
        w_dec = '0;
        case (w_opcode)
            OPC_OP: begin
                w_dec.funct3 = w_f3;
                w_dec.rd     = if_instr[11:7];
                w_dec.val1   = w_op1;
                w_dec.val2   = w_op2;
                w_dec.mod    = if_instr[30];
            end
            OPC_OP_IMM: begin
                w_dec.funct3    = w_f3;
                w_dec.rd        = if_instr[11:7];
                w_dec.immediate = 1'b1;
                w_dec.val1      = w_op1;
                if ((w_f3 == F3_SLL) || (w_f3 == F3_SRL)) begin
                    w_dec.val2 = {27'b0, if_instr[24:20]};
                    w_dec.mod  = (w_f3 == F3_SRL) ? if_instr[30] : 1'b0;
                end else begin
                    w_dec.val2 = imm_i_sext(if_instr);
                end
            end
            default: begin
                w_dec.illegal = 1'b1;
            end
        endcase
    end

    assign if_ready  = !r_vld_p1 || ex_ready;
    assign w_capture = if_valid && if_ready;

    // Stage p1: payload register, held untouched while the ALU stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_pl_p1  <= '0;
        end else if (w_capture) begin
            r_vld_p1 <= 1'b1;
            r_pl_p1  <= w_dec;
        end else if (ex_ready) begin
            r_vld_p1 <= 1'b0;
        end
    end

    assign ex_valid     = r_vld_p1;
    assign ex_funct3    = r_pl_p1.funct3;
    assign ex_mod       = r_pl_p1.mod;
    assign ex_immediate = r_pl_p1.immediate;
    assign ex_val1      = r_pl_p1.val1;
    assign ex_val2      = r_pl_p1.val2;
    assign ex_rd        = r_pl_p1.rd;
    assign ex_illegal   = r_pl_p1.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios then randomized traffic, checked against
// an instruction-level reference model (register array + one-entry payload slot).
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic        ex_valid;
    logic        ex_ready;
    logic [2:0]  ex_funct3;
    logic        ex_mod;
    logic        ex_immediate;
    logic [31:0] ex_val1;
    logic [31:0] ex_val2;
    logic [4:0]  ex_rd;
    logic        ex_illegal;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    id_stage dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_instr     (if_instr),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_funct3    (ex_funct3),
        .ex_mod       (ex_mod),
        .ex_immediate (ex_immediate),
        .ex_val1      (ex_val1),
        .ex_val2      (ex_val2),
        .ex_rd        (ex_rd),
        .ex_illegal   (ex_illegal),
        .wb_en        (wb_en),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
    );

    typedef struct packed {
        logic [2:0]  f3;
        logic        md;
        logic        im;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [4:0]  rd;
        logic        il;
    } pl_t;

    logic [31:0] mregs [32];
    pl_t         mpl;
    logic        mvld;
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] src(input logic [4:0] r, input logic we,
                                        input logic [4:0] wrd, input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
`ifdef RV32I_WB_BYPASS_EN
        if (we && wrd == r) return wd;
`endif
        return mregs[r];
    endfunction

    function automatic pl_t model_decode(input logic [31:0] ins, input logic we,
                                         input logic [4:0] wrd, input logic [31:0] wd);
        pl_t p = '0;
        logic [6:0] opc = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        if (opc == 7'b0110011) begin
            p.f3 = f3; p.rd = ins[11:7]; p.md = ins[30];
            p.v1 = src(ins[19:15], we, wrd, wd);
            p.v2 = src(ins[24:20], we, wrd, wd);
        end else if (opc == 7'b0010011) begin
            p.f3 = f3; p.rd = ins[11:7]; p.im = 1'b1;
            p.v1 = src(ins[19:15], we, wrd, wd);
            if (f3 == 3'd1 || f3 == 3'd5) begin
                p.v2 = 32'(ins[24:20]);
                p.md = (f3 == 3'd5) && ins[30];
            end else begin
                p.v2 = 32'($signed(ins[31:20]));
            end
        end else begin
            p.il = 1'b1;
        end
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("if_ready",     32'(if_ready),     32'(!mvld || ex_ready));
        chk("ex_valid",     32'(ex_valid),     32'(mvld));
        chk("ex_funct3",    32'(ex_funct3),    32'(mpl.f3));
        chk("ex_mod",       32'(ex_mod),       32'(mpl.md));
        chk("ex_immediate", 32'(ex_immediate), 32'(mpl.im));
        chk("ex_val1",      ex_val1,           mpl.v1);
        chk("ex_val2",      ex_val2,           mpl.v2);
        chk("ex_rd",        32'(ex_rd),        32'(mpl.rd));
        chk("ex_illegal",   32'(ex_illegal),   32'(mpl.il));
    endtask

    task automatic model_reset();
        mvld = 1'b0;
        mpl  = '0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    endtask

    // Drive one cycle: apply inputs, check mid-cycle, advance model and clock.
    task automatic step(input logic v, input logic [31:0] ins, input logic rdy,
                        input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                        input logic r);
        logic cap;
        if_valid = v; if_instr = ins; ex_ready = rdy;
        wb_en = we; wb_rd = wrd; wb_data = wd; rst = r;
        @(negedge clk);
        check_all();
        if (r) begin
            model_reset();
        end else begin
            cap = v && (!mvld || rdy);
            if (cap) begin
                mpl  = model_decode(ins, we, wrd, wd);
                mvld = 1'b1;
            end else if (rdy) begin
                mvld = 1'b0;
            end
            if (we && wrd != 5'd0) mregs[wrd] = wd;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] x = $urandom;
        int k = $urandom_range(0, 3);
        x[19:15] = 5'($urandom_range(0, 3));
        case (k)
            0: begin
                x[6:0] = 7'b0110011;
                x[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
                x[24:20] = 5'($urandom_range(0, 3));
            end
            1: x[6:0] = 7'b0010011;
            2: x[6:0] = 7'b0110011;
            default: begin
                if (x[6:0] == 7'b0110011 || x[6:0] == 7'b0010011) x[6:0] = 7'b0000011;
            end
        endcase
        return x;
    endfunction

    initial begin
        logic [31:0] exp_v1;
        rst = 1'b1; if_valid = 1'b0; if_instr = 32'd0; ex_ready = 1'b0;
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state, and wb_en ignored while in reset
        step(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b1, 5'd1, 32'd5, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b1, 5'd2, 32'd7, 1'b0);

        // ADD x3,x1,x2
        step(1'b1, rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("add_valid", 32'(ex_valid), 32'd1);
        chk("add_f3",    32'(ex_funct3), 32'd0);
        chk("add_val1",  ex_val1, 32'd5);
        chk("add_val2",  ex_val2, 32'd7);
        chk("add_mod",   32'(ex_mod), 32'd0);
        chk("add_rd",    32'(ex_rd), 32'd3);

        // Three-cycle stall with a write to x1 in progress
        for (int i = 0; i < 3; i++)
            step(1'b1, itype(12'hFFF, 5'd1, 3'd0, 5'd4, 7'b0010011), 1'b0, 1'b1, 5'd1, 32'h99, 1'b0);
        chk("stall_ready", 32'(if_ready), 32'd0);
        chk("stall_val1",  ex_val1, 32'd5);
        chk("stall_rd",    32'(ex_rd), 32'd3);

        // ADDI x4,x1,-1 accepted as the ADD is consumed
        step(1'b1, itype(12'hFFF, 5'd1, 3'd0, 5'd4, 7'b0010011), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("addi_imm",  32'(ex_immediate), 32'd1);
        chk("addi_val2", ex_val2, 32'hFFFF_FFFF);
        chk("addi_val1", ex_val1, 32'h99);

        step(1'b0, 32'd0, 1'b1, 1'b1, 5'd1, 32'd5, 1'b0);

        // SRAI x5,x1,3
        step(1'b1, itype(12'h403, 5'd1, 3'd5, 5'd5, 7'b0010011), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("srai_f3",   32'(ex_funct3), 32'd5);
        chk("srai_mod",  32'(ex_mod), 32'd1);
        chk("srai_val2", ex_val2, 32'd3);

        // SUB x6,x1,x1 with a same-cycle write to x1
        step(1'b1, rtype(7'h20, 5'd1, 5'd1, 3'd0, 5'd6), 1'b1, 1'b1, 5'd1, 32'h10, 1'b0);
`ifdef RV32I_WB_BYPASS_EN
        exp_v1 = 32'h10;
`else
        exp_v1 = 32'd5;
`endif
        chk("sub_val1", ex_val1, exp_v1);
        chk("sub_val2", ex_val2, exp_v1);
        chk("sub_mod",  32'(ex_mod), 32'd1);

        // Load opcode is illegal here
        step(1'b1, itype(12'h004, 5'd1, 3'd2, 5'd5, 7'b0000011), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("ill_flag", 32'(ex_illegal), 32'd1);
        chk("ill_val1", ex_val1, 32'd0);
        chk("ill_rd",   32'(ex_rd), 32'd0);

        // x0 stays zero after a write attempt
        step(1'b0, 32'd0, 1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0);
        step(1'b1, rtype(7'h00, 5'd0, 5'd0, 3'd0, 5'd7), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("x0_val1", ex_val1, 32'd0);
        chk("x0_val2", ex_val2, 32'd0);

        // Reset while stalled drops the payload
        step(1'b1, rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd8), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        step(1'b1, rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd8), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        step(1'b1, rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd8), 1'b0, 1'b1, 5'd2, 32'd1, 1'b1);
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_val1",  ex_val1, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), rand_instr(), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 1) != 0), 5'($urandom_range(0, 3)), $urandom,
                 ($urandom_range(0, 49) == 0));
        end
        @(negedge clk);
        check_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have port if_valid  in  1  fetch presents an instruction.
REQ-004 SHALL have port if_ready  out  1  stage accepts the instruction this cycle.
REQ-005 SHALL have port if_instr  in  32  RV32I instruction word.
REQ-006 SHALL have port ex_valid  out  1  execute-side payload valid.
REQ-007 SHALL have port ex_ready  in  1  ALU stage consumes payload this cycle.
REQ-008 SHALL have ports ex_funct3 (out 3), ex_mod (out 1), ex_immediate (out 1), ex_val1 (out 32), ex_val2 (out 32), ex_rd (out 5), ex_illegal (out 1): registered ALU operands and control.
REQ-009 SHALL have ports wb_en (in 1), wb_rd (in 5), wb_data (in 32): register-file write port from writeback.

Function
REQ-010 SHALL contain a 32x32 register file; reads of x0 return 0; writes with wb_rd=0 are discarded.
REQ-011 SHALL write wb_data to wb_rd on a rising edge when wb_en=1 and rst=0.
REQ-012 SHALL drive if_ready = !ex_valid || ex_ready (combinational, single-entry pipeline register).
REQ-013 SHALL capture decoded payload on the edge where if_valid && if_ready; ex_valid=1 next cycle (latency 1).
REQ-014 SHALL clear ex_valid when ex_ready=1 and no new capture occurs; back-to-back capture+consume keeps ex_valid=1 with new payload.
REQ-015 SHALL hold all ex_* outputs stable while ex_valid && !ex_ready, including when a write-back to a source register occurs during the stall.
REQ-016 SHALL decode opcode 0110011 (OP): immediate=0, val1=x[rs1], val2=x[rs2], mod=instr[30].
REQ-017 SHALL decode opcode 0010011 (OP-IMM): immediate=1, val1=x[rs1], val2=sign-extended instr[31:20]; for funct3 001/101 val2={27'b0,instr[24:20]}; mod=instr[30] only for funct3 101, else 0.
REQ-018 SHALL set funct3=instr[14:12], rd=instr[11:7] for both opcodes.
REQ-019 SHALL, for any other opcode, capture ex_illegal=1 with all other payload fields zero; handshake unchanged.
REQ-020 SHALL read operands in the capture cycle; a same-cycle write to a source register follows REQ-026.

Reset
REQ-021 SHALL, while rst=1, set ex_valid=0, all ex_* payload outputs 0, all 32 registers 0; wb_en and if_valid are ignored.
REQ-022 SHALL drive if_ready=1 in the first cycle after rst deasserts.
REQ-023 SHALL discard an in-flight payload when rst asserts mid-stall.

Configuration
REQ-024 SHALL use macro RV32I_WB_BYPASS_EN.
REQ-025 SHALL, without the macro, return the pre-write register value when wb_rd equals rs1/rs2 in the capture cycle.
REQ-026 SHALL, with the macro, return wb_data for that operand (never for rd=0).

Structure
REQ-027 SHALL take opcode constants (OP, OP_IMM) and funct3 codes (ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND) from shared package rv32i_pkg, also used by the ALU.
REQ-028 SHALL instantiate sub-module regfile (2 async read ports, 1 sync write port, sync reset).

Verification
REQ-029 SHALL verify: write x1=0x00000005, then issue ADD x3,x1,x2 (x2=7) -> ex_funct3=000, ex_val1=5, ex_val2=7, ex_mod=0, ex_rd=3, one cycle later.
REQ-030 SHALL verify: ADDI x4,x1,-1 -> ex_immediate=1, ex_val2=0xFFFFFFFF; SRAI x5,x1,3 -> ex_funct3=101, ex_mod=1, ex_val2=3.
REQ-031 SHALL verify: ex_ready=0 for 3 cycles with if_valid=1 -> if_ready=0, ex_* unchanged, write to x1 during stall leaves ex_val1 unchanged.
REQ-032 SHALL verify: capture SUB x6,x1,x1 with wb_en=1, wb_rd=1, wb_data=0x10 same cycle -> ex_val1=0x10 with macro, 5 without; ex_mod=1.
REQ-033 SHALL verify: opcode 0000011 -> ex_illegal=1, payload zero; write to x0 then read x0 -> 0; rst during stall -> ex_valid=0 next cycle.
